// File: rtl/countdown_seg_pkg.sv
// Shared types, segment patterns and BCD helpers for the countdown display.
package countdown_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-low patterns ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = SEG_0;

  // Decrement a packed BCD value by one; zero digits borrow to 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Force any non-decimal nibble down to 9.
  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_seg_seg_decode.sv
// Combinational BCD to active-low seven-segment decoder with blanking.
module seg_decode
  import countdown_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/countdown_seg.sv
// BCD countdown timer with a multiplexed seven-segment display.
// o_state and o_count expose the FSM state and count for observation.
module countdown_seg
  import countdown_seg_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_preset,
  input  logic                  i_start,
  input  logic                  i_pause,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_expired,
  output logic                  o_running,
  output state_t                o_state,
  output logic [4*DIGITS-1:0]   o_count
);

  localparam int CW = 4 * DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_presc;
  logic            r_expired;
  logic            r_running;
  logic [SW-1:0]   r_scan;
  logic [DW-1:0]   r_digit;
  logic [DIGITS-1:0] r_an;
  logic [6:0]      r_seg;

  logic [15:0]     w_dec16;
  logic [15:0]     w_clamp16;
  logic [CW-1:0]   w_dec;
  logic [CW-1:0]   w_clamp;
  logic            w_wrap;
  logic            w_count_zero;
  logic [DIGITS-1:0] w_lz;
  logic [3:0]      w_cur;
  logic            w_cur_lz;
  logic            w_blank;
  logic [6:0]      w_seg;

  assign w_dec16      = bcd_dec(16'(r_count));
  assign w_clamp16    = bcd_clamp(16'(i_preset));
  assign w_dec        = w_dec16[CW-1:0];
  assign w_clamp      = w_clamp16[CW-1:0];
  assign w_wrap       = (r_presc == TW'(TICK_DIV - 1));
  assign w_count_zero = (r_count == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_presc   <= '0;
      r_expired <= 1'b0;
      r_running <= 1'b0;
    end else if (i_load) begin
      r_state   <= ST_IDLE;
      r_count   <= w_clamp;
      r_presc   <= '0;
      r_expired <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_presc <= '0;
            if (w_count_zero) begin
              r_state   <= ST_DONE;
              r_expired <= 1'b1;
            end else begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A wrap always decrements, even when pause arrives on the same cycle.
          if (w_wrap) begin
            r_presc <= '0;
            r_count <= w_dec;
            if (w_dec == '0) begin
              r_state   <= ST_DONE;
              r_expired <= 1'b1;
              r_running <= 1'b0;
            end else if (i_pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end
          end else if (i_pause) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!i_pause) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_DONE: begin
          r_expired <= 1'b1;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // w_lz[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic acc;
    acc  = 1'b1;
    w_lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc     = acc & (r_count[i*4 +: 4] == 4'd0);
      w_lz[i] = acc;
    end
  end

  always_comb begin
    w_cur    = 4'd0;
    w_cur_lz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_digit == DW'(i)) begin
        w_cur    = r_count[i*4 +: 4];
        w_cur_lz = w_lz[i];
      end
    end
  end

  assign w_blank = BLANK_LZ && (r_digit != '0) && w_cur_lz;

  seg_decode u_seg_decode (
    .i_bcd   (w_cur),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  // Digit enable and segments are registered from the same index so they change together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan  <= '0;
      r_digit <= '0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan  <= '0;
        r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_an  <= ~(DIGITS'(1) << r_digit);
      r_seg <= w_seg;
    end
  end

  assign o_seg     = r_seg;
  assign o_an      = r_an;
  assign o_expired = r_expired;
  assign o_running = r_running;
  assign o_state   = r_state;
  assign o_count   = r_count;

endmodule
